csl_addsub_pipe: RTL and testbench



---
 rtl/csl_addsub_pipe_if.sv | 27 ++
 rtl/csl_addsub_pipe.sv | 121 ++++++++++++
 tb/tb_csl_addsub_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csl_addsub_pipe_if.sv
// Operand/result handshake bundle for csl_addsub_pipe.
// master = operand producer / result consumer side, slave = the adder.
interface csl_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );
endinterface

// File: rtl/csl_addsub_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Optional saturation on signed overflow when CSL_SAT_EN is defined.
module csl_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input logic              clk,
  input logic              rst,
  csl_addsub_pipe_if.slave bus
);
  localparam int NB = WIDTH / BLK;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum0_next, sum1_next;
  logic [NB-1:0]    c0_next, c1_next;
  logic             accept;
  logic             s1_adv;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] sum0_reg, sum1_reg;
  logic [NB-1:0]    c0_reg, c1_reg;
  logic             cin0_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;

  logic [NB:0]      c_chain;
  logic [WIDTH-1:0] raw_next;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;
  logic             zero_next;

  logic             s2_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;

  assign b_eff        = bus.b ^ {WIDTH{bus.sub}};
  assign s1_adv       = !s2_valid_reg || bus.out_ready;
  assign bus.in_ready = !s1_valid_reg || s1_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  // Speculative block sums for both possible carry-ins.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_pre
      assign {c0_next[gi], sum0_next[gi*BLK +: BLK]} =
        {1'b0, bus.a[gi*BLK +: BLK]} + {1'b0, b_eff[gi*BLK +: BLK]};
      assign {c1_next[gi], sum1_next[gi*BLK +: BLK]} =
        {1'b0, bus.a[gi*BLK +: BLK]} + {1'b0, b_eff[gi*BLK +: BLK]} + (BLK+1)'(1);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // S1 payload needs no reset: it is only observed behind s1_valid_reg.
  always_ff @(posedge clk) begin
    if (accept) begin
      sum0_reg  <= sum0_next;
      sum1_reg  <= sum1_next;
      c0_reg    <= c0_next;
      c1_reg    <= c1_next;
      cin0_reg  <= bus.sub;
      a_msb_reg <= bus.a[WIDTH-1];
      b_msb_reg <= b_eff[WIDTH-1];
    end
  end

  assign c_chain[0] = cin0_reg;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_sel
      assign c_chain[gi+1] = c_chain[gi] ? c1_reg[gi] : c0_reg[gi];
      assign raw_next[gi*BLK +: BLK] =
        c_chain[gi] ? sum1_reg[gi*BLK +: BLK] : sum0_reg[gi*BLK +: BLK];
    end
  endgenerate

  assign ovf_next = (a_msb_reg == b_msb_reg) && (raw_next[WIDTH-1] != a_msb_reg);

`ifdef CSL_SAT_EN
  // Clamp toward the sign of A; both operands share that sign on overflow.
  assign res_next = !ovf_next ? raw_next :
                    a_msb_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_next = raw_next;
`endif

  assign zero_next = (res_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      result_reg   <= '0;
      cout_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg <= res_next;
        cout_reg   <= c_chain[NB];
        ovf_reg    <= ovf_next;
        zero_reg   <= zero_next;
      end
    end
  end

  assign bus.out_valid = s2_valid_reg;
  assign bus.result    = result_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;
endmodule

// File: tb/tb_csl_addsub_pipe.sv
// Self-checking bench for csl_addsub_pipe: integer reference model plus scoreboard,
// with directed vectors carrying hand-computed literal results.
module tb_csl_addsub_pipe;
  localparam int WIDTH = 16;
  localparam int BLK   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csl_addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

  csl_addsub_pipe #(.WIDTH(WIDTH), .BLK(BLK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] res;
    logic        c, o, z;
    bit          has_lit;
    logic [15:0] lres;
    logic        lc, lo, lz;
    int          acc_edge;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_miss = 0;
  int   cyc = 0;

  bit          lit_en;
  logic [15:0] lit_res;
  logic        lit_c, lit_o, lit_z;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on the operands.
  function automatic void model(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                                output logic [15:0] r, output logic c, output logic o,
                                output logic z);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (sv) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur > 65535);
    end
    o = (sr > 32767) || (sr < -32768);
    r = ur[15:0];
`ifdef CSL_SAT_EN
    if (o) r = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    z = (r == 16'h0000);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: checks valid/ready/data every cycle, pops on transfer, pushes on accept.
  always @(negedge clk) begin
    exp_t e;
    logic exp_ov, exp_ir;
    if (rst) begin
      q.delete();
    end else begin
      exp_ov = (q.size() > 0) && (cyc >= q[0].acc_edge + 1);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      exp_ir = !(q.size() == 2 && !bus.out_ready);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
      if (bus.out_valid && q.size() > 0) begin
        chk("result/cout/ovf/zero", {13'd0, bus.result, bus.cout, bus.ovf, bus.zero},
            {13'd0, q[0].res, q[0].c, q[0].o, q[0].z});
        if (bus.out_ready) begin
          $display("beat out: result=%h cout=%b ovf=%b zero=%b",
                   bus.result, bus.cout, bus.ovf, bus.zero);
          if (q[0].has_lit)
            chk("model vs literal", {13'd0, q[0].res, q[0].c, q[0].o, q[0].z},
                {13'd0, q[0].lres, q[0].lc, q[0].lo, q[0].lz});
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        model(bus.a, bus.b, bus.sub, e.res, e.c, e.o, e.z);
        e.has_lit  = lit_en;
        e.lres     = lit_res;
        e.lc       = lit_c;
        e.lo       = lit_o;
        e.lz       = lit_z;
        e.acc_edge = cyc + 1;
        q.push_back(e);
      end
    end
  end

  // Presents one beat and returns at posedge+1 of the edge that accepted it.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                      input bit le, input logic [15:0] lr, input logic lc, input logic lo,
                      input logic lz);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    lit_en = le; lit_res = lr; lit_c = lc; lit_o = lo; lit_z = lz;
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    bus.sub = sv;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("pending beats after drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    lit_en = 1'b0; lit_res = '0; lit_c = 1'b0; lit_o = 1'b0; lit_z = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset result", 32'(bus.result), 32'd0);
    chk("reset flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    @(posedge clk);
    #1;

    // First vector alone, with explicit latency checks.
    send(16'h1234, 16'h0FCD, 1'b0, 1'b1, 16'h2201, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("latency: not yet valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("latency: valid", 32'(bus.out_valid), 32'd1);
    chk("add result", 32'(bus.result), 32'h2201);
    @(posedge clk);
    #1;
    drain();

    // Directed vectors back-to-back.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef CSL_SAT_EN
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
    send(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    drain();

    // Eight-beat stream with a three-cycle consumer stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [15:0] sa, sb;
          logic [31:0] iv;
          iv = 32'(i);
          sa = 16'(i * 16'h1357 + 16'h0F0F);
          sb = 16'(i * 16'h2468);
          send(sa, sb, iv[0], 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        end
        bus.in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Fill both stages, then reset; the in-flight beats must vanish.
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    send(16'h4444, 16'h1111, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post-reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("post-reset result", 32'(bus.result), 32'd0);
    @(posedge clk);
    #1;
    send(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post-reset latency: not yet valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("post-reset latency: valid", 32'(bus.out_valid), 32'd1);
    chk("post-reset sub result", 32'(bus.result), 32'hFFFE);
    @(posedge clk);
    #1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end
endmodule
